// File: rtl/pwm_duty_sequencer_if.sv
// Target-duty load channel between a host and the PWM duty sequencer.
// The host presents a target duty with a valid flag and holds it until the
// sequencer signals ready in the same cycle.
interface pwm_duty_sequencer_if #(
    parameter int DUTY_W = 4
);
    logic [DUTY_W-1:0] tgt_duty;
    logic              tgt_valid;
    logic              tgt_ready;

    modport master (
        output tgt_duty,
        output tgt_valid,
        input  tgt_ready
    );

    modport slave (
        input  tgt_duty,
        input  tgt_valid,
        output tgt_ready
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// PWM period counter plus duty register with a soft ramp toward a requested
// target. A host load port and inc/dec strobes share the target. The applied
// duty only changes on the last count of a period, so each period is compared
// against a single stable duty value and the output never glitches.
module pwm_duty_sequencer #(
    parameter int PERIOD       = 10,
    parameter int DUTY_W       = 4,
    parameter int MAX_DUTY     = 10,
    parameter int INIT_DUTY    = 5,
    parameter int STEP_PERIODS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    pwm_duty_sequencer_if.slave   tgt_if,
    input  logic                  inc_pulse_i,
    input  logic                  dec_pulse_i,
    input  logic                  abort_i,
    output logic [DUTY_W-1:0]     duty_cur_o,
    output logic                  busy_o,
    output logic                  pwm_out_o
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SC_W  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int CMP_W = ((CNT_W > DUTY_W) ? CNT_W : DUTY_W) + 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(STEP_PERIODS - 1);
    localparam logic [SC_W-1:0]   SC_ONE    = SC_W'(1);
    localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W-1:0] DUTY_INIT = DUTY_W'(INIT_DUTY);
    localparam logic [DUTY_W-1:0] DUTY_ONE  = DUTY_W'(1);
    localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SC_W-1:0]   step_q, step_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;

    logic              bnd_s;
    logic              ready_s;
    logic              accept_s;
    logic [DUTY_W-1:0] req_tgt_s;
    logic [DUTY_W-1:0] duty_step_s;
    logic [CMP_W-1:0]  cnt_ext_s;
    logic [CMP_W-1:0]  duty_ext_s;

    // State register: all sequential state, synchronous reset to the initial duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            step_q   <= {SC_W{1'b0}};
            duty_q   <= DUTY_INIT;
            target_q <= DUTY_INIT;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            duty_q   <= duty_d;
            target_q <= target_d;
        end
    end

    // Period counter and boundary detect; the counter parks at 0 while disabled.
    always_comb begin
        cnt_d = cnt_q;
        bnd_s = en_i && (cnt_q == CNT_LAST);
        if (!en_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Requested target in IDLE: a host load beats a strobe, and coincident
    // strobes cancel. The host value is clamped and strobes saturate, so no
    // out-of-range value is ever stored.
    always_comb begin
        ready_s  = (state_q == S_IDLE) && !rst && !abort_i;
        accept_s = tgt_if.tgt_valid && ready_s;
        if (accept_s) begin
            req_tgt_s = (tgt_if.tgt_duty > DUTY_MAX) ? DUTY_MAX : tgt_if.tgt_duty;
        end else if (inc_pulse_i && !dec_pulse_i) begin
            req_tgt_s = (target_q >= DUTY_MAX) ? DUTY_MAX : (target_q + DUTY_ONE);
        end else if (dec_pulse_i && !inc_pulse_i) begin
            req_tgt_s = (target_q == DUTY_ZERO) ? DUTY_ZERO : (target_q - DUTY_ONE);
        end else begin
            req_tgt_s = target_q;
        end
        duty_step_s = (target_q > duty_q) ? (duty_q + DUTY_ONE) : (duty_q - DUTY_ONE);
    end

    // Next-state logic: abort wins over everything, including a ramp step due
    // on the same edge.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        duty_d   = duty_q;
        target_d = target_q;
        if (abort_i) begin
            state_d  = S_IDLE;
            step_d   = {SC_W{1'b0}};
            target_d = duty_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    target_d = req_tgt_s;
                    if (req_tgt_s != duty_q) begin
                        state_d = S_RAMP;
                        step_d  = {SC_W{1'b0}};
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RAMP: begin
                    if (bnd_s) begin
                        if (step_q == SC_LAST) begin
                            duty_d = duty_step_s;
                            step_d = {SC_W{1'b0}};
                            if (duty_step_s == target_q) begin
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_RAMP;
                            end
                        end else begin
                            step_d = step_q + SC_ONE;
                        end
                    end else begin
                        step_d = step_q;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    step_d   = {SC_W{1'b0}};
                    target_d = duty_q;
                end
            endcase
        end
    end

    // Outputs: PWM compare of registered count against registered duty; reset
    // forces every control output low.
    always_comb begin
        cnt_ext_s        = CMP_W'(cnt_q);
        duty_ext_s       = CMP_W'(duty_q);
        pwm_out_o        = en_i && !rst && (cnt_ext_s < duty_ext_s);
        busy_o           = !rst && (state_q == S_RAMP);
        tgt_if.tgt_ready = ready_s;
        duty_cur_o       = duty_q;
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer: table-driven requests with a
// scoreboard of expected final duty / step count, plus hand-written
// sequences for held requests, abort, enable drop and reset mid-ramp.
module tb_pwm_duty_sequencer;

    localparam int PERIOD = 10;
    localparam int STEPS  = 4;
    localparam int CLK_PER_STEP = PERIOD * STEPS;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       inc;
    logic       dec;
    logic       abort;
    logic [3:0] duty;
    logic       busy;
    logic       pwm;

    pwm_duty_sequencer_if #(.DUTY_W(4)) tif ();

    pwm_duty_sequencer #(
        .PERIOD(10), .DUTY_W(4), .MAX_DUTY(10), .INIT_DUTY(5), .STEP_PERIODS(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .tgt_if      (tif.slave),
        .inc_pulse_i (inc),
        .dec_pulse_i (dec),
        .abort_i     (abort),
        .duty_cur_o  (duty),
        .busy_o      (busy),
        .pwm_out_o   (pwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    use_tgt;
        int    tgt;
        bit    inc;
        bit    dec;
        int    exp_duty;
        int    exp_steps;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int exp_duty_q[$];
    int exp_steps_q[$];
    vec_t vecs[10];

    function automatic vec_t mk(input string nm, input bit ut, input int t,
                                input bit i, input bit d, input int ed, input int es);
        vec_t v;
        v.name = nm; v.use_tgt = ut; v.tgt = t; v.inc = i; v.dec = d;
        v.exp_duty = ed; v.exp_steps = es;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic count_high(output int h);
        h = 0;
        repeat (PERIOD) begin
            if (pwm) h++;
            tick;
        end
    endtask

    task automatic wait_duty(input string name, input int v, input int budget);
        int n;
        n = 0;
        while (int'(duty) != v && n < budget) begin
            tick;
            n++;
        end
        chk(name, int'(duty), v);
    endtask

    // Called on the cycle after a request edge; pops the expectation pushed
    // when the request was driven and follows the ramp until busy drops.
    task automatic run_ramp(input string name);
        int n, changes, bad, prev, e_duty, e_steps;
        n = 0; changes = 0; bad = 0;
        e_duty  = exp_duty_q.pop_front();
        e_steps = exp_steps_q.pop_front();
        prev = int'(duty);
        while (busy && n < e_steps * CLK_PER_STEP + 50) begin
            tick;
            n++;
            if (int'(duty) != prev) begin
                changes++;
                if (!((e_duty > prev && int'(duty) == prev + 1) ||
                      (e_duty < prev && int'(duty) == prev - 1))) bad++;
                prev = int'(duty);
            end
        end
        chk({name, "_final"}, int'(duty), e_duty);
        chk({name, "_busy_end"}, int'(busy), 0);
        chk({name, "_steps"}, changes, e_steps);
        chk({name, "_step_dir"}, bad, 0);
        if (e_steps == 0)
            chk({name, "_clocks"}, n, 0);
        else
            chk({name, "_clocks_in_window"},
                int'(n >= e_steps * CLK_PER_STEP - (PERIOD - 1) && n <= e_steps * CLK_PER_STEP), 1);
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus.
    initial begin
        int h, bad, d0, n;
        vec_t v;

        rst = 1'b1; en = 1'b0; inc = 1'b0; dec = 1'b0; abort = 1'b0;
        tif.tgt_valid = 1'b0; tif.tgt_duty = 4'd0;

        vecs[0] = mk("ramp_up8",  1'b1, 8,  1'b0, 1'b0, 8,  3);
        vecs[1] = mk("clamp15",   1'b1, 15, 1'b0, 1'b0, 10, 2);
        vecs[2] = mk("inc_sat",   1'b0, 0,  1'b1, 1'b0, 10, 0);
        vecs[3] = mk("tgt0",      1'b1, 0,  1'b0, 1'b0, 0,  10);
        vecs[4] = mk("dec_sat",   1'b0, 0,  1'b0, 1'b1, 0,  0);
        vecs[5] = mk("tgt7_inc",  1'b1, 7,  1'b1, 1'b0, 7,  7);
        vecs[6] = mk("inc_dec",   1'b0, 0,  1'b1, 1'b1, 7,  0);
        vecs[7] = mk("inc",       1'b0, 0,  1'b1, 1'b0, 8,  1);
        vecs[8] = mk("dec",       1'b0, 0,  1'b0, 1'b1, 7,  1);
        vecs[9] = mk("tgt_same",  1'b1, 7,  1'b0, 1'b0, 7,  0);

        // Reset for two clocks.
        tick;
        tick;
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(tif.tgt_ready), 0);
        rst = 1'b0; en = 1'b1;
        tick;
        chk("post_rst_duty", int'(duty), 5);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_ready", int'(tif.tgt_ready), 1);

        // 30 clocks at duty 5: high on counts 0..4 only.
        h = 0; bad = 0;
        repeat (30) begin
            if (pwm) h++;
            if (int'(pwm) != int'(dut.cnt_q < 4'd5)) bad++;
            tick;
        end
        chk("idle_pwm_highs", h, 15);
        chk("idle_pwm_shape", bad, 0);

        // Table-driven requests.
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            if (v.use_tgt) begin
                chk({v.name, "_ready"}, int'(tif.tgt_ready), 1);
                tif.tgt_valid = 1'b1;
                tif.tgt_duty  = 4'(v.tgt);
            end
            inc = v.inc; dec = v.dec;
            exp_duty_q.push_back(v.exp_duty);
            exp_steps_q.push_back(v.exp_steps);
            tick;
            tif.tgt_valid = 1'b0; inc = 1'b0; dec = 1'b0;
            chk({v.name, "_busy_start"}, int'(busy), int'(v.exp_steps > 0));
            run_ramp(v.name);
            count_high(h);
            chk({v.name, "_pwm_highs"}, h, v.exp_duty);
        end

        // Request held through a ramp is accepted on the first IDLE cycle.
        inc = 1'b1;
        tick;
        inc = 1'b0;
        chk("held_busy", int'(busy), 1);
        tif.tgt_valid = 1'b1; tif.tgt_duty = 4'd4;
        #1;
        chk("held_ready_low", int'(tif.tgt_ready), 0);
        n = 0;
        while (!tif.tgt_ready && n < 100) begin
            tick;
            n++;
        end
        chk("held_ready_back", int'(tif.tgt_ready), 1);
        chk("held_duty_at_ready", int'(duty), 8);
        exp_duty_q.push_back(4);
        exp_steps_q.push_back(4);
        tick;
        tif.tgt_valid = 1'b0;
        chk("held_accept_busy", int'(busy), 1);
        run_ramp("held");

        // Abort during 5->9 at duty 7, with a competing load in the same cycle.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_start_duty", int'(duty), 5);
        tif.tgt_valid = 1'b1; tif.tgt_duty = 4'd9;
        tick;
        tif.tgt_valid = 1'b0;
        wait_duty("abort_reach7", 7, 120);
        repeat (3) tick;
        abort = 1'b1; tif.tgt_valid = 1'b1; tif.tgt_duty = 4'd2;
        #1;
        chk("abort_ready_low", int'(tif.tgt_ready), 0);
        tick;
        abort = 1'b0; tif.tgt_valid = 1'b0;
        #1;
        chk("abort_duty", int'(duty), 7);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(tif.tgt_ready), 1);
        repeat (100) tick;
        chk("abort_frozen", int'(duty), 7);
        chk("abort_idle", int'(busy), 0);

        // Enable dropped mid-ramp: output low, counter parked, ramp paused.
        tif.tgt_valid = 1'b1; tif.tgt_duty = 4'd9;
        tick;
        tif.tgt_valid = 1'b0;
        repeat (15) tick;
        d0 = int'(duty);
        en = 1'b0;
        bad = 0;
        repeat (50) begin
            tick;
            if (pwm !== 1'b0 || dut.cnt_q != 4'd0 || int'(duty) != d0 || busy !== 1'b1) bad++;
        end
        chk("en_off_hold", bad, 0);
        en = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            tick;
            n++;
        end
        chk("en_resume_duty", int'(duty), 9);
        chk("en_resume_busy", int'(busy), 0);
        count_high(h);
        chk("en_resume_pwm", h, 9);

        // Reset in the middle of a 5->9 ramp.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tif.tgt_valid = 1'b1; tif.tgt_duty = 4'd9;
        tick;
        tif.tgt_valid = 1'b0;
        wait_duty("rst_mid_reach6", 6, 60);
        repeat (2) tick;
        rst = 1'b1;
        #1;
        chk("rst_mid_pwm", int'(pwm), 0);
        chk("rst_mid_ready", int'(tif.tgt_ready), 0);
        tick;
        chk("rst_mid_duty", int'(duty), 5);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_cnt", int'(dut.cnt_q), 0);
        rst = 1'b0;
        bad = 0;
        repeat (200) begin
            tick;
            if (int'(duty) != 5 || busy !== 1'b0) bad++;
        end
        chk("rst_mid_no_steps", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
